// File: rtl/status_uart_tx.sv
// status_uart_tx: snapshots a status byte and sends "S<hi><lo>\r\n" as 8N1 UART text, LSB first.
// Define STATUS_TX_CHECKSUM_EN to insert two hex checksum characters (XOR of the first three bytes) before CR.
module status_uart_tx #(
   parameter int CLK_PER_BIT = 100,
   parameter int AUTO_PERIOD = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] status,
   input  logic       send,
   input  logic       tx_block,
   output logic       tx,
   output logic       busy,
   output logic       done
);

`ifdef STATUS_TX_CHECKSUM_EN
   localparam int NUM_BYTES = 7;
`else
   localparam int NUM_BYTES = 5;
`endif
   localparam int              CW        = $clog2(CLK_PER_BIT);
   localparam logic [CW-1:0]   CNT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [2:0]      BYTE_LAST = 3'(NUM_BYTES - 1);

   // The byte-boundary decision is taken on the last STOP cycle rather than in a
   // separate state, so every byte is exactly 10 bit times on the wire.
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [2:0]      byte_q, byte_d;
   logic [7:0]      snap_q, snap_d;
   logic            pend_q, pend_d;
   logic            relaunch_q, relaunch_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            auto_req;
   logic            req;
   logic            bit_end;
   logic [7:0]      data_byte;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] packet_byte(input logic [2:0] idx, input logic [7:0] snap);
      logic [7:0] hi;
      logic [7:0] lo;
`ifdef STATUS_TX_CHECKSUM_EN
      logic [7:0] cs;
`endif
      hi = hex_char(snap[7:4]);
      lo = hex_char(snap[3:0]);
`ifdef STATUS_TX_CHECKSUM_EN
      cs = 8'h53 ^ hi ^ lo;
      case (idx)
         3'd0:    return 8'h53;
         3'd1:    return hi;
         3'd2:    return lo;
         3'd3:    return hex_char(cs[7:4]);
         3'd4:    return hex_char(cs[3:0]);
         3'd5:    return 8'h0D;
         default: return 8'h0A;
      endcase
`else
      case (idx)
         3'd0:    return 8'h53;
         3'd1:    return hi;
         3'd2:    return lo;
         3'd3:    return 8'h0D;
         default: return 8'h0A;
      endcase
`endif
   endfunction

   assign req     = send | auto_req;
   assign bit_end = (cnt_q == CNT_LAST);

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = bit_end ? '0 : cnt_q + 1'b1;
      bit_d      = bit_q;
      byte_d     = byte_q;
      snap_d     = snap_q;
      pend_d     = pend_q;
      relaunch_d = relaunch_q;
      done_d     = 1'b0;

      if (state_q != S_IDLE && req) pend_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (req || relaunch_q) begin
               snap_d     = status;
               byte_d     = '0;
               relaunch_d = 1'b0;
               state_d    = tx_block ? S_WAIT : S_START;
            end
         end
         S_WAIT: begin
            if (!tx_block) state_d = S_START;
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (byte_q == BYTE_LAST) begin
                  // A request landing on the done cycle still counts as the one pending request.
                  state_d    = S_IDLE;
                  done_d     = 1'b1;
                  relaunch_d = pend_q | req;
                  pend_d     = 1'b0;
               end else begin
                  byte_d  = byte_q + 1'b1;
                  state_d = tx_block ? S_WAIT : S_START;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) cnt_d = '0;

      data_byte = packet_byte(byte_d, snap_d);
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = data_byte[bit_d];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // NOTE: flops use non-blocking assignments so each one samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         byte_q     <= '0;
         snap_q     <= '0;
         pend_q     <= 1'b0;
         relaunch_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_q      <= bit_d;
         byte_q     <= byte_d;
         snap_q     <= snap_d;
         pend_q     <= pend_d;
         relaunch_q <= relaunch_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   generate
      if (AUTO_PERIOD > 0) begin : g_auto
         localparam int            AW        = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
         localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
         logic [AW-1:0] auto_q;

         assign auto_req = (auto_q == AUTO_LAST);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        auto_q <= '0;
            else if (auto_req) auto_q <= '0;
            else               auto_q <= auto_q + 1'b1;
         end
      end else begin : g_no_auto
         assign auto_req = 1'b0;
      end
   endgenerate

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
